// File: rtl/pixel_stream_packer_pkg.sv
// Shared types and defaults for the pixel stream packer.
package pixel_stream_packer_pkg;

  // Default pixel width used by the interface and the top level.
  localparam int PIX_W_DEF = 8;

  // Capture sequencer states; WAIT12 is the reset state.
  typedef enum logic [1:0] {
    WAIT12 = 2'd0,
    DLY12  = 2'd1,
    WAIT34 = 2'd2,
    DLY34  = 2'd3
  } state_t;

  // One stream word as stored in the FIFO, MSB first: {sof, eof, data}.
  typedef struct packed {
    logic                 sof;
    logic                 eof;
    logic [PIX_W_DEF-1:0] data;
  } entry_t;

endpackage

// File: rtl/pixel_stream_packer_if.sv
// Byte stream with valid/ready handshake and frame markers.
interface pixel_stream_packer_if
  import pixel_stream_packer_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) ();

  logic [PIX_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sof;
  logic             out_eof;

  modport master (
    output out_data,
    output out_valid,
    output out_sof,
    output out_eof,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_sof,
    input  out_eof,
    output out_ready
  );

endinterface

// File: rtl/pixel_stream_packer_sync_fifo.sv
// FIFO with a two-word write port and a registered first-word-fall-through
// read port. The output register counts towards DEPTH, so free_cnt reflects
// the total number of words the block can still accept.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_wr,
  input  logic [W-1:0]           i_wd0,
  input  logic [W-1:0]           i_wd1,
  input  logic                   i_rd_ready,
  output logic                   o_rd_valid,
  output logic [W-1:0]           o_rd_data,
  output logic [$clog2(DEPTH):0] o_free_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_out_valid;
  logic [W-1:0]  r_out_data;

  logic [CW-1:0] w_occ;
  logic [CW-1:0] w_free;
  logic          w_wr_ok;
  logic          w_pop;
  logic          w_load;

  // Occupancy, write acceptance and output-register refill decisions.
  always_comb begin
    w_occ   = r_count + {{AW{1'b0}}, r_out_valid};
    w_free  = CW'(DEPTH) - w_occ;
    w_wr_ok = i_wr && (w_free >= CW'(2));
    w_pop   = r_out_valid & i_rd_ready;
    w_load  = (~r_out_valid | w_pop) & (r_count != CW'(0));
  end

  // Storage, pointers and the output register; a write never bypasses
  // storage, so data reaches the output one cycle after it is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_wr_ok) begin
        r_mem[r_wr_ptr]          <= i_wd0;
        r_mem[r_wr_ptr + AW'(1)] <= i_wd1;
        r_wr_ptr                 <= r_wr_ptr + AW'(2);
      end
      if (w_load) begin
        r_out_data  <= r_mem[r_rd_ptr];
        r_out_valid <= 1'b1;
        r_rd_ptr    <= r_rd_ptr + AW'(1);
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
      r_count <= r_count + (w_wr_ok ? CW'(2) : CW'(0)) - (w_load ? CW'(1) : CW'(0));
    end
  end

  assign o_rd_valid = r_out_valid;
  assign o_rd_data  = r_out_data;
  assign o_free_cnt = w_free;

endmodule

// File: rtl/pixel_stream_packer.sv
// Captures pixel pairs on the read12/read34 strobes and packs them into a
// P1,P2,P3,P4 byte stream with sof/eof markers, frame counting and error flags.
module pixel_stream_packer
  import pixel_stream_packer_pkg::*;
#(
  parameter int PIX_W      = PIX_W_DEF,
  parameter int DEPTH      = 8,
  parameter int SAMPLE_DLY = 2,
  parameter int FCNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read12,
  input  logic              read34,
  input  logic [PIX_W-1:0]  pix_in1,
  input  logic [PIX_W-1:0]  pix_in2,
  input  logic [PIX_W-1:0]  pix_in3,
  input  logic [PIX_W-1:0]  pix_in4,
  input  logic              clear_err,
  output logic              overflow,
  output logic              proto_err,
  output logic [FCNT_W-1:0] frame_cnt,
  pixel_stream_packer_if.master strm
);

  localparam int         EW        = PIX_W + 2;
  localparam int         FW        = $clog2(DEPTH) + 1;
  localparam logic [3:0] DLY_INIT  = 4'(SAMPLE_DLY);
  localparam logic       DLY_ZERO  = (SAMPLE_DLY == 0);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_rd12_q;
  logic              r_rd34_q;
  logic              r_overflow;
  logic              r_proto_err;
  logic [FCNT_W-1:0] r_frame_cnt;

  logic              w_rise12;
  logic              w_rise34;
  logic [3:0]        w_cnt_dec;
  logic              w_cap12;
  logic              w_cap34;
  logic              w_perr;
  logic              w_fits;
  logic              w_wr;
  logic              w_drop;
  logic [EW-1:0]     w_wd0;
  logic [EW-1:0]     w_wd1;
  logic              w_rd_valid;
  logic [EW-1:0]     w_rd_data;
  logic [FW-1:0]     w_free_cnt;

  // Strobe edges, capture strobes, protocol errors and the FIFO write words.
  // Captures are combinational so a zero sample delay writes in the rise cycle.
  always_comb begin
    w_rise12  = read12 & ~r_rd12_q;
    w_rise34  = read34 & ~r_rd34_q;
    w_cnt_dec = r_cnt - 4'd1;
    w_cap12   = 1'b0;
    w_cap34   = 1'b0;
    w_perr    = 1'b0;
    case (r_state)
      WAIT12: begin
        if (w_rise12) begin
          w_perr  = w_rise34;
          w_cap12 = DLY_ZERO;
        end else if (w_rise34) begin
          w_perr = 1'b1;
        end else begin
          w_perr = 1'b0;
        end
      end
      DLY12: begin
        w_perr  = w_rise12 | w_rise34;
        w_cap12 = (w_cnt_dec == 4'd0);
      end
      WAIT34: begin
        if (w_rise12) begin
          w_perr  = 1'b1;
          w_cap12 = DLY_ZERO;
        end else if (w_rise34) begin
          w_cap34 = DLY_ZERO;
        end else begin
          w_perr = 1'b0;
        end
      end
      DLY34: begin
        w_perr  = w_rise12 | w_rise34;
        w_cap34 = (w_cnt_dec == 4'd0);
      end
      default: begin
        w_perr = 1'b0;
      end
    endcase
    w_fits = (w_free_cnt >= FW'(2));
    w_wr   = (w_cap12 | w_cap34) & w_fits;
    w_drop = (w_cap12 | w_cap34) & ~w_fits;
    if (w_cap12) begin
      w_wd0 = {1'b1, 1'b0, pix_in1};
      w_wd1 = {1'b0, 1'b0, pix_in2};
    end else begin
      w_wd0 = {1'b0, 1'b0, pix_in3};
      w_wd1 = {1'b0, 1'b1, pix_in4};
    end
  end

  // Sequencer state, delay counter, edge history, sticky flags and frame count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= WAIT12;
      r_cnt       <= 4'd0;
      r_rd12_q    <= 1'b0;
      r_rd34_q    <= 1'b0;
      r_overflow  <= 1'b0;
      r_proto_err <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_rd12_q <= read12;
      r_rd34_q <= read34;
      case (r_state)
        WAIT12: begin
          if (w_rise12) begin
            r_state <= DLY_ZERO ? WAIT34 : DLY12;
            r_cnt   <= DLY_INIT;
          end
        end
        DLY12: begin
          r_cnt <= w_cnt_dec;
          if (w_cnt_dec == 4'd0) begin
            r_state <= WAIT34;
          end
        end
        WAIT34: begin
          if (w_rise12) begin
            // Restart the frame from P1/P2.
            r_state <= DLY_ZERO ? WAIT34 : DLY12;
            r_cnt   <= DLY_INIT;
          end else if (w_rise34) begin
            r_state <= DLY_ZERO ? WAIT12 : DLY34;
            r_cnt   <= DLY_INIT;
          end
        end
        DLY34: begin
          r_cnt <= w_cnt_dec;
          if (w_cnt_dec == 4'd0) begin
            r_state <= WAIT12;
          end
        end
        default: begin
          r_state <= WAIT12;
        end
      endcase
      // A new error in the clearing cycle keeps its flag set.
      r_overflow  <= w_drop | (r_overflow & ~clear_err);
      r_proto_err <= w_perr | (r_proto_err & ~clear_err);
      // Dropped P3/P4 pairs still count as completed frames.
      if (w_cap34) begin
        r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
      end
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .i_wr       (w_wr),
    .i_wd0      (w_wd0),
    .i_wd1      (w_wd1),
    .i_rd_ready (strm.out_ready),
    .o_rd_valid (w_rd_valid),
    .o_rd_data  (w_rd_data),
    .o_free_cnt (w_free_cnt)
  );

  assign strm.out_valid = w_rd_valid;
  assign strm.out_data  = w_rd_data[PIX_W-1:0];
  assign strm.out_eof   = w_rd_data[PIX_W];
  assign strm.out_sof   = w_rd_data[PIX_W+1];
  assign overflow       = r_overflow;
  assign proto_err      = r_proto_err;
  assign frame_cnt      = r_frame_cnt;

endmodule
